pipe_stage_regs: RTL and testbench
==================================

Name: pipe_stage_regs

Overview:
Consumer end of the hazard-control interface. It holds the PC, IF/ID and ID/EX pipeline registers of the 5-stage MIPS core and applies StallF, StallD, FlushE and branch redirect with exact cycle semantics. It sits between the fetch/decode datapath and the execute stage, and is driven by the hazard detection unit.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0000, instruction word injected on an IF/ID flush (sll $0,$0,0).
CNT_W, 32, width of the performance counters (PERF_CNT_EN only).

Ports:
clk  in  1  core clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
StallF  in  1  hold PC.
StallD  in  1  hold IF/ID.
FlushE  in  1  insert a bubble into ID/EX.
PCSrcD  in  1  branch taken, resolved in Decode.
PCBranchD  in  32  branch target.
InstrF  in  32  instruction from instruction memory.
RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD  in  1 each  decode controls.
ALUControlD  in  3  ALU operation.
RsD, RtD, RdD  in  5 each  register indices.
RD1D, RD2D, SignImmD  in  32 each  operands.
PCF  out  32  fetch PC.
InstrD, PCPlus4D  out  32 each  IF/ID contents.
ValidD, ValidE  out  1 each  stage holds a real instruction, not a bubble.
RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE  out  1 each  registered controls.
ALUControlE  out  3;  RsE, RtE, RdE  out  5 each;  RD1E, RD2E, SignImmE  out  32 each.

Behaviour:
- Reset (async, active-high): PCF=RESET_PC. InstrD=NOP_INSTR. ValidD=0, ValidE=0. All other outputs 0. Counters 0.
- PC register: redirect = PCSrcD & ~StallD.
  - StallF=1: hold PCF.
  - StallF=0 and redirect=1: PCF <= PCBranchD.
  - Otherwise: PCF <= PCF+4, mod 2^32 (0xFFFF_FFFC wraps to 0).
- IF/ID, priority order:
  1. redirect: InstrD <= NOP_INSTR, PCPlus4D <= 0, ValidD <= 0.
  2. StallD: hold.
  3. Else: InstrD <= InstrF, PCPlus4D <= PCF+4, ValidD <= 1.
- ID/EX never stalls. The hazard unit stalls only F and D.
  - FlushE=1: all E outputs <= 0, ValidE <= 0. RegWriteE=MemWriteE=0 guarantees no architectural side effect.
  - Else: load every D field and set ValidE <= ValidD.
- Single-cycle latency through each register. No combinational path from inputs to outputs.
- Simultaneous events:
  - StallF=StallD=FlushE=1 (branch or load stall): PC and IF/ID hold, E gets a bubble.
  - PCSrcD=1 with StallD=1: the redirect is ignored this cycle. The branch re-evaluates next cycle with valid forwarding.
  - StallF=0 with StallD=1 is an illegal combination. Checked by assertion; the RTL treats it as StallF=1.
- Reset mid-stall or mid-flush: the asynchronous reset wins immediately. The first post-reset fetch is RESET_PC.

Optional Feature:
PIPE_PERF_CNT_EN.
- Defined: adds outputs StallCnt, FlushCnt and RetireE, each CNT_W bits.
  - StallCnt increments on each cycle with StallD=1.
  - FlushCnt increments on each cycle with FlushE=1 or redirect=1. It counts once if both occur in the same cycle.
  - RetireE increments when ValidE=1.
  - All three counters saturate at all-ones. Reset clears them.
- Undefined: the ports and logic are absent. Behaviour is otherwise identical.

Decomposition:
- pipe_pkg holds:
  - the NOP constant;
  - REG_IDX_W=5;
  - a packed ctrl_t struct {RegWrite, MemtoReg, MemWrite, ALUSrc, RegDst, ALUControl[2:0]};
  - a CTRL_BUBBLE constant (all zeros).
- One sub-module, pipe_reg_en_clr: a generic width-parameterised register with async reset, enable and synchronous clear, where clear has priority over enable. It is instantiated for the PC, IF/ID and ID/EX registers.

Test Plan:
- Reset release, no stalls, InstrF=0x2008_0005 → PCF sequence 0,4,8. After 1 cycle InstrD=0x2008_0005, PCPlus4D=4. After 2 cycles ValidE=1.
- Load-use stall for 1 cycle: StallF=StallD=FlushE=1 at PCF=0x10 → PCF holds 0x10 and InstrD holds. Next cycle RegWriteE=0 and ValidE=0. The following cycle resumes with PCF=0x14.
- Branch taken: PCSrcD=1, PCBranchD=0x40, no stalls → next cycle PCF=0x40, InstrD=0, ValidD=0. The one after, PCF=0x44.
- Branch under stall: PCSrcD=1 with StallD=1 → PCF unchanged and IF/ID unchanged. Next cycle PCSrcD=1, StallD=0 → PCF=0x40.
- PC wrap: RESET_PC=0xFFFF_FFF8 → PCF 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Async reset asserted mid-cycle during a stall → outputs go to reset values before the next edge. With PIPE_PERF_CNT_EN: 3 stall cycles then reset → StallCnt reads 3 before reset and 0 after.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage registers.
package pipe_pkg;

    localparam logic [31:0] NOP = 32'h0000_0000;  // sll $0,$0,0
    localparam int REG_IDX_W = 5;

    typedef struct packed {
        logic       RegWrite;
        logic       MemtoReg;
        logic       MemWrite;
        logic       ALUSrc;
        logic       RegDst;
        logic [2:0] ALUControl;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_reg_en_clr.sv
// Generic register: async reset, synchronous clear (wins over enable), enable.
module pipe_reg_en_clr #(
    parameter int             W       = 32,
    parameter logic [W-1:0]   RST_VAL = '0,
    parameter logic [W-1:0]   CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)      q <= RST_VAL;
        else if (clr)   q <= CLR_VAL;
        else if (en)    q <= d;
    end

endmodule

// File: rtl/pipe_stage_regs.sv
// PC, IF/ID and ID/EX registers of the 5-stage MIPS core under hazard control.
// Optional perf counters (StallCnt, FlushCnt, RetireE) under PIPE_PERF_CNT_EN.
module pipe_stage_regs
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = pipe_pkg::NOP
`ifdef PIPE_PERF_CNT_EN
    ,parameter int         CNT_W     = 32
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 StallF,
    input  logic                 StallD,
    input  logic                 FlushE,
    input  logic                 PCSrcD,
    input  logic [31:0]          PCBranchD,
    input  logic [31:0]          InstrF,
    input  logic                 RegWriteD,
    input  logic                 MemtoRegD,
    input  logic                 MemWriteD,
    input  logic                 ALUSrcD,
    input  logic                 RegDstD,
    input  logic [2:0]           ALUControlD,
    input  logic [REG_IDX_W-1:0] RsD,
    input  logic [REG_IDX_W-1:0] RtD,
    input  logic [REG_IDX_W-1:0] RdD,
    input  logic [31:0]          RD1D,
    input  logic [31:0]          RD2D,
    input  logic [31:0]          SignImmD,
    output logic [31:0]          PCF,
    output logic [31:0]          InstrD,
    output logic [31:0]          PCPlus4D,
    output logic                 ValidD,
    output logic                 ValidE,
    output logic                 RegWriteE,
    output logic                 MemtoRegE,
    output logic                 MemWriteE,
    output logic                 ALUSrcE,
    output logic                 RegDstE,
    output logic [2:0]           ALUControlE,
    output logic [REG_IDX_W-1:0] RsE,
    output logic [REG_IDX_W-1:0] RtE,
    output logic [REG_IDX_W-1:0] RdE,
    output logic [31:0]          RD1E,
    output logic [31:0]          RD2E,
    output logic [31:0]          SignImmE
`ifdef PIPE_PERF_CNT_EN
    ,output logic [CNT_W-1:0]    StallCnt
    ,output logic [CNT_W-1:0]    FlushCnt
    ,output logic [CNT_W-1:0]    RetireE
`endif
);

    localparam int IFID_W = 32 + 32 + 1;
    localparam int EX_W   = $bits(ctrl_t) + 3 * REG_IDX_W + 3 * 32 + 1;

    logic        redirect;
    logic        holdF;
    logic [31:0] pcPlus4F;
    logic [31:0] pcNext;
    ctrl_t       ctrlD;
    ctrl_t       ctrlE;
    logic [EX_W-1:0] exD;
    logic [EX_W-1:0] exQ;

    // A branch seen while Decode is stalled is dropped; it re-resolves next cycle.
    assign redirect = PCSrcD & ~StallD;
    // StallD without StallF is illegal; fetch holds so the stalled slot is not lost.
    assign holdF    = StallF | StallD;
    assign pcPlus4F = PCF + 32'd4;
    assign pcNext   = redirect ? PCBranchD : pcPlus4F;

    pipe_reg_en_clr #(.W(32), .RST_VAL(RESET_PC), .CLR_VAL(RESET_PC)) pcReg (
        .clk(clk), .reset(reset), .en(~holdF), .clr(1'b0), .d(pcNext), .q(PCF)
    );

    pipe_reg_en_clr #(
        .W(IFID_W),
        .RST_VAL({NOP_INSTR, 32'h0, 1'b0}),
        .CLR_VAL({NOP_INSTR, 32'h0, 1'b0})
    ) ifIdReg (
        .clk(clk), .reset(reset), .en(~StallD), .clr(redirect),
        .d({InstrF, pcPlus4F, 1'b1}),
        .q({InstrD, PCPlus4D, ValidD})
    );

    assign ctrlD = '{RegWrite: RegWriteD, MemtoReg: MemtoRegD, MemWrite: MemWriteD,
                     ALUSrc: ALUSrcD, RegDst: RegDstD, ALUControl: ALUControlD};
    assign exD   = {ctrlD, RsD, RtD, RdD, RD1D, RD2D, SignImmD, ValidD};

    pipe_reg_en_clr #(
        .W(EX_W),
        .RST_VAL('0),
        .CLR_VAL({CTRL_BUBBLE, {(EX_W - $bits(ctrl_t)){1'b0}}})
    ) idExReg (
        .clk(clk), .reset(reset), .en(1'b1), .clr(FlushE), .d(exD), .q(exQ)
    );

    assign {ctrlE, RsE, RtE, RdE, RD1E, RD2E, SignImmE, ValidE} = exQ;
    assign RegWriteE   = ctrlE.RegWrite;
    assign MemtoRegE   = ctrlE.MemtoReg;
    assign MemWriteE   = ctrlE.MemWrite;
    assign ALUSrcE     = ctrlE.ALUSrc;
    assign RegDstE     = ctrlE.RegDst;
    assign ALUControlE = ctrlE.ALUControl;

`ifdef PIPE_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Saturating counters; a flush and a redirect in one cycle count once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            StallCnt <= '0;
            FlushCnt <= '0;
            RetireE  <= '0;
        end else begin
            if (StallD && StallCnt != '1)               StallCnt <= StallCnt + CNT_ONE;
            if ((FlushE || redirect) && FlushCnt != '1) FlushCnt <= FlushCnt + CNT_ONE;
            if (ValidE && RetireE != '1)                RetireE  <= RetireE + CNT_ONE;
        end
    end
`endif

    illegalStall: assert property (@(posedge clk) disable iff (reset) !(StallD && !StallF));

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Directed bench for pipe_stage_regs: reset, stalls, flushes, redirects, PC wrap, async reset.
module tb_pipe_stage_regs;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallF, StallD, FlushE, PCSrcD;
    logic [31:0] PCBranchD, InstrF;
    logic        RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD;
    logic [2:0]  ALUControlD;
    logic [4:0]  RsD, RtD, RdD;
    logic [31:0] RD1D, RD2D, SignImmD;

    logic [31:0] PCF, InstrD, PCPlus4D;
    logic        ValidD, ValidE;
    logic        RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE;
    logic [2:0]  ALUControlE;
    logic [4:0]  RsE, RtE, RdE;
    logic [31:0] RD1E, RD2E, SignImmE;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] StallCnt, FlushCnt, RetireE;
    logic [31:0] wStallCnt, wFlushCnt, wRetireE;
`endif

    // wrap instance: idle inputs, only PCF observed
    logic        zero1  = 1'b0;
    logic [2:0]  zero3  = '0;
    logic [4:0]  zero5  = '0;
    logic [31:0] zero32 = '0;
    logic [31:0] wPCF, wInstrD, wPCPlus4D, wRD1E, wRD2E, wSignImmE;
    logic        wValidD, wValidE, wRegWriteE, wMemtoRegE, wMemWriteE, wALUSrcE, wRegDstE;
    logic [2:0]  wALUControlE;
    logic [4:0]  wRsE, wRtE, wRdE;

    int checkCnt = 0;
    int errCnt   = 0;
    logic [31:0] exp_q[$];

    pipe_stage_regs dut (
        .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
        .PCSrcD(PCSrcD), .PCBranchD(PCBranchD), .InstrF(InstrF),
        .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
        .ALUSrcD(ALUSrcD), .RegDstD(RegDstD), .ALUControlD(ALUControlD),
        .RsD(RsD), .RtD(RtD), .RdD(RdD), .RD1D(RD1D), .RD2D(RD2D), .SignImmD(SignImmD),
        .PCF(PCF), .InstrD(InstrD), .PCPlus4D(PCPlus4D), .ValidD(ValidD), .ValidE(ValidE),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
        .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .ALUControlE(ALUControlE),
        .RsE(RsE), .RtE(RtE), .RdE(RdE), .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE)
`ifdef PIPE_PERF_CNT_EN
        , .StallCnt(StallCnt), .FlushCnt(FlushCnt), .RetireE(RetireE)
`endif
    );

    pipe_stage_regs #(.RESET_PC(32'hFFFF_FFF8)) dutWrap (
        .clk(clk), .reset(reset), .StallF(zero1), .StallD(zero1), .FlushE(zero1),
        .PCSrcD(zero1), .PCBranchD(zero32), .InstrF(zero32),
        .RegWriteD(zero1), .MemtoRegD(zero1), .MemWriteD(zero1),
        .ALUSrcD(zero1), .RegDstD(zero1), .ALUControlD(zero3),
        .RsD(zero5), .RtD(zero5), .RdD(zero5), .RD1D(zero32), .RD2D(zero32), .SignImmD(zero32),
        .PCF(wPCF), .InstrD(wInstrD), .PCPlus4D(wPCPlus4D), .ValidD(wValidD), .ValidE(wValidE),
        .RegWriteE(wRegWriteE), .MemtoRegE(wMemtoRegE), .MemWriteE(wMemWriteE),
        .ALUSrcE(wALUSrcE), .RegDstE(wRegDstE), .ALUControlE(wALUControlE),
        .RsE(wRsE), .RtE(wRtE), .RdE(wRdE), .RD1E(wRD1E), .RD2E(wRD2E), .SignImmE(wSignImmE)
`ifdef PIPE_PERF_CNT_EN
        , .StallCnt(wStallCnt), .FlushCnt(wFlushCnt), .RetireE(wRetireE)
`endif
    );

    // clock: rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic checkWrapPc(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            checkEq({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            checkEq(tag, wPCF, e);
        end
    endtask

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    task automatic setHazard(input logic sf, input logic sd, input logic fe, input logic br,
                             input logic [31:0] tgt);
        StallF    = sf;
        StallD    = sd;
        FlushE    = fe;
        PCSrcD    = br;
        PCBranchD = tgt;
    endtask

    initial begin
        reset = 1'b1;
        setHazard(0, 0, 0, 0, 32'h0);
        InstrF      = 32'h2008_0005;
        RegWriteD   = 1'b1;
        MemtoRegD   = 1'b0;
        MemWriteD   = 1'b1;
        ALUSrcD     = 1'b1;
        RegDstD     = 1'b0;
        ALUControlD = 3'b010;
        RsD = 5'd1; RtD = 5'd2; RdD = 5'd8;
        RD1D = 32'h1234_5678; RD2D = 32'h0BAD_F00D; SignImmD = 32'h0000_0005;
        exp_q.push_back(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);

        // reset state
        #2;
        checkEq("rst_pcf", PCF, 32'h0);
        checkEq("rst_instrd", InstrD, 32'h0);
        checkEq("rst_pcplus4d", PCPlus4D, 32'h0);
        checkEq("rst_validd", {31'b0, ValidD}, 32'h0);
        checkEq("rst_valide", {31'b0, ValidE}, 32'h0);
        checkEq("rst_regwritee", {31'b0, RegWriteE}, 32'h0);
        checkWrapPc("wrap_pc0");
        #10 reset = 1'b0;   // t=12
        checkEq("pcf_seq0", PCF, 32'h0);

        stepClk();          // edge 15
        checkEq("pcf_seq4", PCF, 32'h4);
        checkEq("instrd_first", InstrD, 32'h2008_0005);
        checkEq("pcplus4d_first", PCPlus4D, 32'h4);
        checkEq("validd_first", {31'b0, ValidD}, 32'h1);
        checkEq("valide_one_cycle", {31'b0, ValidE}, 32'h0);
        checkWrapPc("wrap_pc1");

        stepClk();          // edge 25
        checkEq("pcf_seq8", PCF, 32'h8);
        checkEq("valide_two_cycles", {31'b0, ValidE}, 32'h1);
        checkEq("regwritee", {31'b0, RegWriteE}, 32'h1);
        checkEq("memwritee", {31'b0, MemWriteE}, 32'h1);
        checkEq("alucontrole", {29'b0, ALUControlE}, 32'h2);
        checkEq("rde", {27'b0, RdE}, 32'h8);
        checkEq("rd1e", RD1E, 32'h1234_5678);
        checkWrapPc("wrap_pc2");

        stepClk();          // edge 35
        stepClk();          // edge 45
        checkEq("pcf_pre_stall", PCF, 32'h10);

        // load-use stall: hold F and D, bubble into E
        setHazard(1, 1, 1, 0, 32'h0);
        InstrF = 32'hAAAA_0000;
        stepClk();          // edge 55
        checkEq("stall_pcf_hold", PCF, 32'h10);
        checkEq("stall_instrd_hold", InstrD, 32'h2008_0005);
        checkEq("stall_pcplus4d_hold", PCPlus4D, 32'h10);
        checkEq("stall_regwritee", {31'b0, RegWriteE}, 32'h0);
        checkEq("stall_memwritee", {31'b0, MemWriteE}, 32'h0);
        checkEq("stall_valide", {31'b0, ValidE}, 32'h0);
        checkEq("stall_rd1e", RD1E, 32'h0);

        setHazard(0, 0, 0, 0, 32'h0);
        stepClk();          // edge 65
        checkEq("resume_pcf", PCF, 32'h14);
        checkEq("resume_instrd", InstrD, 32'hAAAA_0000);
        checkEq("resume_valide", {31'b0, ValidE}, 32'h1);
        checkEq("resume_regwritee", {31'b0, RegWriteE}, 32'h1);

        // branch taken
        setHazard(0, 0, 0, 1, 32'h40);
        stepClk();          // edge 75
        checkEq("br_pcf", PCF, 32'h40);
        checkEq("br_instrd_nop", InstrD, 32'h0);
        checkEq("br_pcplus4d", PCPlus4D, 32'h0);
        checkEq("br_validd", {31'b0, ValidD}, 32'h0);
        setHazard(0, 0, 0, 0, 32'h0);
        stepClk();          // edge 85
        checkEq("br_pcf_next", PCF, 32'h44);
        checkEq("br_valide_bubble", {31'b0, ValidE}, 32'h0);
        checkEq("br_pcplus4d_next", PCPlus4D, 32'h44);

        // branch under stall is ignored, then taken once D moves
        setHazard(1, 1, 0, 1, 32'h80);
        InstrF = 32'hBBBB_0000;
        stepClk();          // edge 95
        checkEq("brstall_pcf", PCF, 32'h44);
        checkEq("brstall_instrd", InstrD, 32'hAAAA_0000);
        checkEq("brstall_validd", {31'b0, ValidD}, 32'h1);
        setHazard(0, 0, 0, 1, 32'h80);
        stepClk();          // edge 105
        checkEq("brstall_pcf_taken", PCF, 32'h80);
        checkEq("brstall_validd_taken", {31'b0, ValidD}, 32'h0);
`ifdef PIPE_PERF_CNT_EN
        checkEq("cnt_stall", StallCnt, 32'd2);
        checkEq("cnt_flush", FlushCnt, 32'd3);
        checkEq("cnt_retire", RetireE, 32'd6);
`endif
        setHazard(0, 0, 0, 0, 32'h0);

        // fresh reset, two free cycles, then three stall cycles
        #2 reset = 1'b1;    // t=108
        #2 reset = 1'b0;    // t=110
        stepClk();          // edge 115
        stepClk();          // edge 125
        checkEq("seg2_pcf", PCF, 32'h8);
        setHazard(1, 1, 0, 0, 32'h0);
        stepClk();
        stepClk();
        stepClk();          // edge 155
        checkEq("seg2_pcf_hold", PCF, 32'h8);
`ifdef PIPE_PERF_CNT_EN
        checkEq("cnt_stall3", StallCnt, 32'd3);
        checkEq("cnt_flush0", FlushCnt, 32'd0);
`endif

        // async reset mid-stall takes effect before the next edge
        #2 reset = 1'b1;    // t=158
        #1;
        checkEq("async_pcf", PCF, 32'h0);
        checkEq("async_instrd", InstrD, 32'h0);
        checkEq("async_pcplus4d", PCPlus4D, 32'h0);
        checkEq("async_validd", {31'b0, ValidD}, 32'h0);
        checkEq("async_valide", {31'b0, ValidE}, 32'h0);
        checkEq("async_rd1e", RD1E, 32'h0);
`ifdef PIPE_PERF_CNT_EN
        checkEq("async_stallcnt", StallCnt, 32'd0);
        checkEq("async_retire", RetireE, 32'd0);
`endif
        #3;                 // t=162
        reset = 1'b0;
        setHazard(0, 0, 0, 0, 32'h0);
        stepClk();          // edge 165
        checkEq("post_rst_pcf", PCF, 32'h4);
        checkEq("post_rst_first_fetch", PCPlus4D, 32'h4);
        checkEq("post_rst_validd", {31'b0, ValidD}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checkCnt, errCnt);
        $finish;
    end

endmodule
